// File: rtl/elixirchip_es1_spu_op_arbiter_pkg.sv
// rtl/elixirchip_es1_spu_op_arbiter_pkg.sv - shared types for the SPU op arbiter
package elixirchip_es1_spu_op_arbiter_pkg;

  // Wide enough for the largest supported port count (16).
  localparam int TAG_ID_BITS = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                   valid;
    logic [TAG_ID_BITS-1:0] id;
    logic                   clear;
  } op_tag_t;

  localparam op_tag_t TAG_IDLE = '0;

endpackage

// File: rtl/elixirchip_es1_spu_op_arbiter_if.sv
// rtl/elixirchip_es1_spu_op_arbiter_if.sv - requester, op-unit and result bundle of the arbiter
interface elixirchip_es1_spu_op_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_BITS = 8,
  parameter int ID_BITS   = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0][DATA_BITS-1:0] s_data0;
  logic [NUM_PORTS-1:0][DATA_BITS-1:0] s_data1;
  logic [NUM_PORTS-1:0]                s_clear;
  logic [NUM_PORTS-1:0]                s_valid;
  logic [NUM_PORTS-1:0]                s_ready;
  logic                                s_flush;

  logic [DATA_BITS-1:0]                op_data0;
  logic [DATA_BITS-1:0]                op_data1;
  logic                                op_clear;
  logic                                op_valid;
  logic [DATA_BITS-1:0]                op_m_data;

  logic [DATA_BITS-1:0]                m_data;
  logic [ID_BITS-1:0]                  m_id;
  logic                                m_clear;
  logic                                m_valid;
  logic                                flush_done;

  // Arbiter side.
  modport slave (
    input  s_data0, s_data1, s_clear, s_valid, s_flush, op_m_data,
    output s_ready, op_data0, op_data1, op_clear, op_valid,
    output m_data, m_id, m_clear, m_valid, flush_done
  );

  // Requesters, op unit and result consumer side.
  modport master (
    output s_data0, s_data1, s_clear, s_valid, s_flush, op_m_data,
    input  s_ready, op_data0, op_data1, op_clear, op_valid,
    input  m_data, m_id, m_clear, m_valid, flush_done
  );
endinterface

// File: rtl/elixirchip_es1_rr_select.sv
// rtl/elixirchip_es1_rr_select.sv - circular first-one search starting at a pointer
module elixirchip_es1_rr_select #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_BITS  = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_BITS-1:0]  ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_BITS-1:0]  idx_o,
  output logic                 any_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// rtl/elixirchip_es1_spu_op_arbiter.sv - round-robin sharing of one pipelined SPU op unit with tag tracking and flush
module elixirchip_es1_spu_op_arbiter
  import elixirchip_es1_spu_op_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BITS  = 8,
  parameter int OP_LATENCY = 1,
  parameter int ID_BITS    = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cke,
  elixirchip_es1_spu_op_arbiter_if.slave    bus_if
);

  localparam int CNT_BITS = $clog2(OP_LATENCY + 1);

  arb_state_e           state_q, state_d;
  logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_BITS-1:0]  in_flight_q, in_flight_d;
  op_tag_t              tag_q [OP_LATENCY];
  op_tag_t              tag_in;
  op_tag_t              tag_out;

  logic                 grant_en;
  logic                 flush_done;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic [ID_BITS-1:0]   grant_idx;
  logic                 grant_any;
  logic                 xfer;
  logic                 retire;

  assign req = bus_if.s_valid & {NUM_PORTS{grant_en}};

  elixirchip_es1_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_BITS  (ID_BITS)
  ) u_rr_select (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // grant_en already folds in cke, so any grant is a completed transfer.
  assign xfer           = grant_any;
  assign bus_if.s_ready = grant;

  assign bus_if.op_valid = xfer;
  assign bus_if.op_data0 = xfer ? bus_if.s_data0[grant_idx] : '0;
  assign bus_if.op_data1 = xfer ? bus_if.s_data1[grant_idx] : '0;
  assign bus_if.op_clear = xfer & bus_if.s_clear[grant_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (grant_idx == ID_BITS'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    tag_in       = TAG_IDLE;
    tag_in.valid = xfer;
    tag_in.id    = TAG_ID_BITS'(grant_idx);
    tag_in.clear = bus_if.op_clear;
  end

  // Tags mirror the op unit pipeline, which advances on the same cke.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OP_LATENCY; i++) tag_q[i] <= TAG_IDLE;
    end else if (cke) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < OP_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[OP_LATENCY-1];

  assign bus_if.m_data  = bus_if.op_m_data;
  assign bus_if.m_valid = tag_out.valid;
  assign bus_if.m_id    = tag_out.id[ID_BITS-1:0];
  assign bus_if.m_clear = tag_out.clear;

  assign retire = tag_out.valid & cke;

  always_comb begin
    in_flight_d = in_flight_q;
    case ({xfer, retire})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight_q <= '0;
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush with nothing outstanding still spends one cycle in DRAIN.
  always_comb begin
    state_d = state_q;
    if (cke) begin
      case (state_q)
        ST_RUN:   if (bus_if.s_flush) state_d = ST_DRAIN;
        ST_DRAIN: if (in_flight_q == '0) state_d = ST_DONE;
        ST_DONE:  state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    grant_en   = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN:  grant_en   = cke & ~bus_if.s_flush;
      ST_DONE: flush_done = cke;
      default: begin
        grant_en   = 1'b0;
        flush_done = 1'b0;
      end
    endcase
  end

  assign bus_if.flush_done = flush_done;

endmodule
